cp0_access_arbiter: RTL
=======================

CP0_ACCESS_ARBITER -- requirements
Module: cp0_access_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive exception grants while a pipeline request waits.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-004 SHALL have port exc_req  in  1: exception unit write request, held until exc_ack.
REQ-005 SHALL have ports exc_addr  in  5 and exc_wdata  in  32: exception write register index and data.
REQ-006 SHALL have port exc_ack  out  1: one-cycle pulse; exception write performed this cycle.
REQ-007 SHALL have port pip_req  in  1: pipeline MTC0/MFC0 request, held until pip_ack.
REQ-008 SHALL have ports pip_we  in  1 (1 = write, 0 = read), pip_addr  in  5 and pip_wdata  in  32.
REQ-009 SHALL have ports pip_ack  out  1 (one-cycle pulse) and pip_rdata  out  32 (read result, valid with pip_ack, held afterwards).
REQ-010 SHALL have ports cp0_addr  out  5, cp0_wdata  out  32, cp0_we  out  1 and cp0_re  out  1: CP0 register-file port.
REQ-011 SHALL have port cp0_rdata  in  32: register-file read data, valid the cycle after cp0_re.
REQ-012 SHALL have port busy  out  1: high whenever the FSM is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EXC_WR, PIP_WR, PIP_RD, RD_WAIT, RD_RESP.
REQ-014 Requests SHALL be sampled only in IDLE; on grant, the winner's addr, wdata and we SHALL be latched and held stable for the whole transfer.
REQ-015 Priority SHALL be exception over pipeline, except when starve_cnt == STARVE_MAX and pip_req is high, in which case the pipeline SHALL win.
REQ-016 starve_cnt SHALL increment on an exception grant while pip_req is high, clear on a pipeline grant, clear on an exception grant while pip_req is low, and saturate at STARVE_MAX.
REQ-017 Exception write SHALL run IDLE -> EXC_WR -> IDLE, with cp0_we=1 and exc_ack=1 in EXC_WR (latency: request in IDLE cycle N, write and ack in cycle N+1).
REQ-018 Pipeline write SHALL run IDLE -> PIP_WR -> IDLE, with cp0_we=1 and pip_ack=1 in PIP_WR.
REQ-019 Pipeline read SHALL run IDLE -> PIP_RD (cp0_re=1) -> RD_WAIT (capture cp0_rdata into rdata_q) -> RD_RESP (pip_ack=1, pip_rdata=rdata_q) -> IDLE; the ack comes in cycle N+3.
REQ-020 cp0_we and cp0_re SHALL never be high in the same cycle, and SHALL be 0 in IDLE, RD_WAIT and RD_RESP.
REQ-021 cp0_addr and cp0_wdata SHALL equal the latched request fields in every non-IDLE state, and 0 in IDLE.
REQ-022 pip_rdata SHALL hold the last read value until the next RD_WAIT capture; a write SHALL NOT alter it.
REQ-023 With both requests high in the same IDLE cycle, only one SHALL be granted; the loser stays pending and is re-arbitrated in the next IDLE cycle.
REQ-024 At least one IDLE cycle SHALL separate consecutive transfers; requesters drop req on the edge where ack is sampled.
REQ-025 Address values 0-31 SHALL all pass unchanged; no decoding is done.

Reset
REQ-026 While rst is high: state=IDLE, starve_cnt=0, rdata_q=0, latched fields=0, and every output=0.
REQ-027 Reset mid-transfer SHALL abort the transfer with no ack issued and no further cp0_we/cp0_re.

Structure
REQ-028 Package cp0_pkg SHALL hold the state enum, CP0_AW=5, CP0_DW=32 and the register indices STATUS=12, CAUSE=13, EPC=14.
REQ-029 Request-holding and rdata_q registers SHALL use the team's enable flop flopren; no other sub-module.
REQ-030 starve_cnt width SHALL be $clog2(STARVE_MAX+1).

Verification
REQ-031 Exception write only: exc_req=1, addr=14, wdata=0xBFC00380 -> next cycle cp0_we=1, cp0_addr=14, exc_ack=1; busy low again one cycle later.
REQ-032 Pipeline read: addr=12, register file returns 0x0040FF01 -> cp0_re one cycle after request, pip_ack three cycles after request, pip_rdata=0x0040FF01 and held thereafter.
REQ-033 Simultaneous requests, exc addr 13 and pip write addr 12 -> exception is granted first, the pipeline write follows after one IDLE cycle.
REQ-034 Starvation: exc_req held continuously, pip_req held -> exactly 4 exception acks, then pip_ack, with starve_cnt back to 0.
REQ-035 rst asserted during RD_WAIT -> all outputs 0 immediately, no pip_ack; a fresh read after release completes normally.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: arbiter FSM states, register-file geometry and
// the architectural register indices the exception path writes most often.
package cp0_pkg;

  localparam int CP0_AW = 5;
  localparam int CP0_DW = 32;

  localparam logic [CP0_AW-1:0] STATUS = 5'd12;
  localparam logic [CP0_AW-1:0] CAUSE  = 5'd13;
  localparam logic [CP0_AW-1:0] EPC    = 5'd14;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXC_WR  = 3'd1,
    PIP_WR  = 3'd2,
    PIP_RD  = 3'd3,
    RD_WAIT = 3'd4,
    RD_RESP = 3'd5
  } cp0_state_e;

endpackage

// File: rtl/flopren.sv
// Enable flop with asynchronous active-high reset to zero.
module flopren #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled, otherwise hold; reset clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cp0_access_arbiter.sv
// Arbitrates the single CP0 register-file port between the exception unit
// (writes only) and the pipeline (MTC0 writes / MFC0 reads).
//
// Handshake: a requester raises req with its fields stable and holds all of
// them until it sees its ack pulse high at a rising edge; it drops req on that
// same edge. Requests are only looked at in IDLE, the winner's fields are
// latched at the grant edge, and every transfer returns to IDLE before the
// next grant, so consecutive transfers are always separated by one IDLE cycle.
import cp0_pkg::*;

module cp0_access_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             exc_req,
  input  logic [CP0_AW-1:0]                exc_addr,
  input  logic [CP0_DW-1:0]                exc_wdata,
  output logic                             exc_ack,
  input  logic                             pip_req,
  input  logic                             pip_we,
  input  logic [CP0_AW-1:0]                pip_addr,
  input  logic [CP0_DW-1:0]                pip_wdata,
  output logic                             pip_ack,
  output logic [CP0_DW-1:0]                pip_rdata,
  output logic [CP0_AW-1:0]                cp0_addr,
  output logic [CP0_DW-1:0]                cp0_wdata,
  output logic                             cp0_we,
  output logic                             cp0_re,
  input  logic [CP0_DW-1:0]                cp0_rdata,
  output logic                             busy,
  output cp0_state_e                       dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]  dbg_starve_cnt
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);
  localparam int REQW = 1 + CP0_AW + CP0_DW;

  cp0_state_e          state_q, state_d;
  logic [SCW-1:0]      starve_q, starve_d;
  logic                starved, exc_win, pip_win, grant;
  logic                we_d, we_q;
  logic [CP0_AW-1:0]   addr_d, addr_q;
  logic [CP0_DW-1:0]   wdata_d, wdata_q;
  logic [CP0_DW-1:0]   rdata_q;
  logic                rd_capture;

  // Arbitration: exception first unless the pipeline has been passed over
  // STARVE_MAX times in a row and is still waiting.
  always_comb begin
    starved = pip_req && (starve_q == STARVE_LIM);
    exc_win = (state_q == IDLE) && exc_req && !starved;
    pip_win = (state_q == IDLE) && pip_req && !exc_win;
    grant   = exc_win || pip_win;
    we_d    = exc_win ? 1'b1      : pip_we;
    addr_d  = exc_win ? exc_addr  : pip_addr;
    wdata_d = exc_win ? exc_wdata : pip_wdata;
  end

  // Starvation counter: counts exception wins over a waiting pipeline, saturating.
  always_comb begin
    starve_d = starve_q;
    if (exc_win) begin
      if (!pip_req)                 starve_d = '0;
      else if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
    end else if (pip_win) begin
      starve_d = '0;
    end
  end

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (exc_win)      state_d = EXC_WR;
        else if (pip_win) state_d = pip_we ? PIP_WR : PIP_RD;
      end
      EXC_WR:  state_d = IDLE;
      PIP_WR:  state_d = IDLE;
      PIP_RD:  state_d = RD_WAIT;
      RD_WAIT: state_d = RD_RESP;
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Winner's request fields, frozen for the whole transfer.
  flopren #(.W(REQW)) u_req_hold (
    .clk (clk),
    .rst (rst),
    .en  (grant),
    .d   ({we_d, addr_d, wdata_d}),
    .q   ({we_q, addr_q, wdata_q})
  );

  assign rd_capture = (state_q == RD_WAIT);

  // Read result; only a completed read's capture cycle updates it.
  flopren #(.W(CP0_DW)) u_rdata_hold (
    .clk (clk),
    .rst (rst),
    .en  (rd_capture),
    .d   (cp0_rdata),
    .q   (rdata_q)
  );

  // Register-file port and acknowledges decoded from the current state.
  always_comb begin
    cp0_addr  = '0;
    cp0_wdata = '0;
    cp0_we    = 1'b0;
    cp0_re    = 1'b0;
    exc_ack   = 1'b0;
    pip_ack   = 1'b0;
    busy      = 1'b0;
    if (state_q != IDLE) begin
      busy      = 1'b1;
      cp0_addr  = addr_q;
      cp0_wdata = wdata_q;
    end
    case (state_q)
      EXC_WR:  begin cp0_we = we_q; exc_ack = 1'b1; end
      PIP_WR:  begin cp0_we = we_q; pip_ack = 1'b1; end
      PIP_RD:  cp0_re  = !we_q;
      RD_RESP: pip_ack = 1'b1;
      default: ;
    endcase
  end

  assign pip_rdata      = rdata_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule
